axi4_ram_arbiter: RTL

AXI4_RAM_ARBITER -- requirements
Module: axi4_ram_arbiter

---
 rtl/axi4_arb_pkg.sv | 17 +
 rtl/axi4_rr_pick.sv | 27 ++
 rtl/axi4_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 RAM arbiter.
package axi4_arb_pkg;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_S0 = 1'b0;
  localparam req_idx_t REQ_S1 = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_rr_pick.sv
// Two-way grant picker: pointer breaks ties, or requester 0 always wins when
// AXI_ARB_FIXED_PRIO_EN is defined.
module axi4_rr_pick
  import axi4_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   ptr,
  output req_idx_t   grant
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic [1:0] unused_bits;
  assign unused_bits = {ptr, req[1]};
  assign grant = req[0] ? REQ_S0 : REQ_S1;
`else
  always_comb begin
    if (req == 2'b11) begin
      grant = ptr;
    end else if (req[1]) begin
      grant = REQ_S1;
    end else begin
      grant = REQ_S0;
    end
  end
`endif

endmodule

// File: rtl/axi4_ram_arbiter.sv
// Two-requester AXI4 arbiter onto a single RAM port; independent write and read
// paths, round-robin by default, fixed priority with AXI_ARB_FIXED_PRIO_EN.
module axi4_ram_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester 0
  input  logic                    s0_aw_valid,
  input  logic [ID_WIDTH-1:0]     s0_aw_id,
  input  logic [ADDR_WIDTH-1:0]   s0_aw_addr,
  input  logic [7:0]              s0_aw_len,
  input  logic [2:0]              s0_aw_size,
  input  logic [1:0]              s0_aw_burst,
  output logic                    s0_aw_ready,
  input  logic                    s0_w_valid,
  input  logic [DATA_WIDTH-1:0]   s0_w_data,
  input  logic [DATA_WIDTH/8-1:0] s0_w_strb,
  input  logic                    s0_w_last,
  output logic                    s0_w_ready,
  output logic                    s0_b_valid,
  output logic [ID_WIDTH-1:0]     s0_b_id,
  output logic [1:0]              s0_b_resp,
  input  logic                    s0_b_ready,
  input  logic                    s0_ar_valid,
  input  logic [ID_WIDTH-1:0]     s0_ar_id,
  input  logic [ADDR_WIDTH-1:0]   s0_ar_addr,
  input  logic [7:0]              s0_ar_len,
  input  logic [2:0]              s0_ar_size,
  input  logic [1:0]              s0_ar_burst,
  output logic                    s0_ar_ready,
  output logic                    s0_r_valid,
  output logic [ID_WIDTH-1:0]     s0_r_id,
  output logic [DATA_WIDTH-1:0]   s0_r_data,
  output logic [1:0]              s0_r_resp,
  output logic                    s0_r_last,
  input  logic                    s0_r_ready,
  // requester 1
  input  logic                    s1_aw_valid,
  input  logic [ID_WIDTH-1:0]     s1_aw_id,
  input  logic [ADDR_WIDTH-1:0]   s1_aw_addr,
  input  logic [7:0]              s1_aw_len,
  input  logic [2:0]              s1_aw_size,
  input  logic [1:0]              s1_aw_burst,
  output logic                    s1_aw_ready,
  input  logic                    s1_w_valid,
  input  logic [DATA_WIDTH-1:0]   s1_w_data,
  input  logic [DATA_WIDTH/8-1:0] s1_w_strb,
  input  logic                    s1_w_last,
  output logic                    s1_w_ready,
  output logic                    s1_b_valid,
  output logic [ID_WIDTH-1:0]     s1_b_id,
  output logic [1:0]              s1_b_resp,
  input  logic                    s1_b_ready,
  input  logic                    s1_ar_valid,
  input  logic [ID_WIDTH-1:0]     s1_ar_id,
  input  logic [ADDR_WIDTH-1:0]   s1_ar_addr,
  input  logic [7:0]              s1_ar_len,
  input  logic [2:0]              s1_ar_size,
  input  logic [1:0]              s1_ar_burst,
  output logic                    s1_ar_ready,
  output logic                    s1_r_valid,
  output logic [ID_WIDTH-1:0]     s1_r_id,
  output logic [DATA_WIDTH-1:0]   s1_r_data,
  output logic [1:0]              s1_r_resp,
  output logic                    s1_r_last,
  input  logic                    s1_r_ready,
  // downstream RAM port
  output logic                    m_aw_valid,
  output logic [ID_WIDTH-1:0]     m_aw_id,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [7:0]              m_aw_len,
  output logic [2:0]              m_aw_size,
  output logic [1:0]              m_aw_burst,
  input  logic                    m_aw_ready,
  output logic                    m_w_valid,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_last,
  input  logic                    m_w_ready,
  input  logic                    m_b_valid,
  input  logic [ID_WIDTH-1:0]     m_b_id,
  input  logic [1:0]              m_b_resp,
  output logic                    m_b_ready,
  output logic                    m_ar_valid,
  output logic [ID_WIDTH-1:0]     m_ar_id,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [7:0]              m_ar_len,
  output logic [2:0]              m_ar_size,
  output logic [1:0]              m_ar_burst,
  input  logic                    m_ar_ready,
  input  logic                    m_r_valid,
  input  logic [ID_WIDTH-1:0]     m_r_id,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_last,
  output logic                    m_r_ready
);

  wr_state_e w_state_q;
  rd_state_e r_state_q;
  req_idx_t  w_gnt_q, r_gnt_q;
  req_idx_t  w_pick, r_pick;
  req_idx_t  w_ptr, r_ptr;

  logic w_addr_st, w_data_st, w_resp_st, r_addr_st, r_data_st;
  logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  assign w_addr_st = (w_state_q == W_ADDR);
  assign w_data_st = (w_state_q == W_DATA);
  assign w_resp_st = (w_state_q == W_RESP);
  assign r_addr_st = (r_state_q == R_ADDR);
  assign r_data_st = (r_state_q == R_DATA);

  assign aw_hs     = m_aw_valid && m_aw_ready;
  assign w_last_hs = m_w_valid && m_w_ready && m_w_last;
  assign b_hs      = m_b_valid && m_b_ready;
  assign ar_hs     = m_ar_valid && m_ar_ready;
  assign r_last_hs = m_r_valid && m_r_ready && m_r_last;

  axi4_rr_pick u_w_pick (
    .req   ({s1_aw_valid, s0_aw_valid}),
    .ptr   (w_ptr),
    .grant (w_pick)
  );

  axi4_rr_pick u_r_pick (
    .req   ({s1_ar_valid, s0_ar_valid}),
    .ptr   (r_ptr),
    .grant (r_pick)
  );

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign w_ptr = REQ_S0;
  assign r_ptr = REQ_S0;
`else
  req_idx_t w_ptr_q, r_ptr_q;

  // Pointer hands priority to the other requester once a transaction retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= REQ_S0;
      r_ptr_q <= REQ_S0;
    end else begin
      if (w_resp_st && b_hs) w_ptr_q <= ~w_gnt_q;
      if (r_data_st && r_last_hs) r_ptr_q <= ~r_gnt_q;
    end
  end

  assign w_ptr = w_ptr_q;
  assign r_ptr = r_ptr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_gnt_q   <= REQ_S0;
    end else begin
      unique case (w_state_q)
        W_IDLE: if (s0_aw_valid || s1_aw_valid) begin
          w_gnt_q   <= w_pick;
          w_state_q <= W_ADDR;
        end
        W_ADDR: if (aw_hs) w_state_q <= W_DATA;
        W_DATA: if (w_last_hs) w_state_q <= W_RESP;
        W_RESP: if (b_hs) w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= REQ_S0;
    end else begin
      unique case (r_state_q)
        R_IDLE: if (s0_ar_valid || s1_ar_valid) begin
          r_gnt_q   <= r_pick;
          r_state_q <= R_ADDR;
        end
        R_ADDR: if (ar_hs) r_state_q <= R_DATA;
        R_DATA: if (r_last_hs) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write path routing; handshake signals are gated by phase so an idle or
  // ungranted side never sees a stray valid/ready.
  assign m_aw_valid  = w_addr_st && (w_gnt_q ? s1_aw_valid : s0_aw_valid);
  assign m_aw_id     = w_gnt_q ? s1_aw_id    : s0_aw_id;
  assign m_aw_addr   = w_gnt_q ? s1_aw_addr  : s0_aw_addr;
  assign m_aw_len    = w_gnt_q ? s1_aw_len   : s0_aw_len;
  assign m_aw_size   = w_gnt_q ? s1_aw_size  : s0_aw_size;
  assign m_aw_burst  = w_gnt_q ? s1_aw_burst : s0_aw_burst;
  assign s0_aw_ready = w_addr_st && !w_gnt_q && m_aw_ready;
  assign s1_aw_ready = w_addr_st &&  w_gnt_q && m_aw_ready;

  assign m_w_valid   = w_data_st && (w_gnt_q ? s1_w_valid : s0_w_valid);
  assign m_w_data    = w_gnt_q ? s1_w_data : s0_w_data;
  assign m_w_strb    = w_gnt_q ? s1_w_strb : s0_w_strb;
  assign m_w_last    = w_gnt_q ? s1_w_last : s0_w_last;
  assign s0_w_ready  = w_data_st && !w_gnt_q && m_w_ready;
  assign s1_w_ready  = w_data_st &&  w_gnt_q && m_w_ready;

  assign m_b_ready   = w_resp_st && (w_gnt_q ? s1_b_ready : s0_b_ready);
  assign s0_b_valid  = w_resp_st && !w_gnt_q && m_b_valid;
  assign s1_b_valid  = w_resp_st &&  w_gnt_q && m_b_valid;
  assign s0_b_id     = m_b_id;
  assign s1_b_id     = m_b_id;
  assign s0_b_resp   = m_b_resp;
  assign s1_b_resp   = m_b_resp;

  // Read path routing
  assign m_ar_valid  = r_addr_st && (r_gnt_q ? s1_ar_valid : s0_ar_valid);
  assign m_ar_id     = r_gnt_q ? s1_ar_id    : s0_ar_id;
  assign m_ar_addr   = r_gnt_q ? s1_ar_addr  : s0_ar_addr;
  assign m_ar_len    = r_gnt_q ? s1_ar_len   : s0_ar_len;
  assign m_ar_size   = r_gnt_q ? s1_ar_size  : s0_ar_size;
  assign m_ar_burst  = r_gnt_q ? s1_ar_burst : s0_ar_burst;
  assign s0_ar_ready = r_addr_st && !r_gnt_q && m_ar_ready;
  assign s1_ar_ready = r_addr_st &&  r_gnt_q && m_ar_ready;

  assign m_r_ready   = r_data_st && (r_gnt_q ? s1_r_ready : s0_r_ready);
  assign s0_r_valid  = r_data_st && !r_gnt_q && m_r_valid;
  assign s1_r_valid  = r_data_st &&  r_gnt_q && m_r_valid;
  assign s0_r_id     = m_r_id;
  assign s1_r_id     = m_r_id;
  assign s0_r_data   = m_r_data;
  assign s1_r_data   = m_r_data;
  assign s0_r_resp   = m_r_resp;
  assign s1_r_resp   = m_r_resp;
  assign s0_r_last   = m_r_last;
  assign s1_r_last   = m_r_last;

endmodule
